rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource (issue port, writeback port, bus slot) among `WIDTH` requesters. It sits between the requesting units and the shared resource. The block picks a winner with two first-priority `priority_finder` searches (a masked search and an unmasked search), registers the grant, and holds it until the resource accepts it with a valid/ready handshake. After each accepted grant, priority rotates to the requester just after the winner, so no requester can starve another.

---
 rtl/rr_arbiter.sv | 139 +++++++++++++
 tb/tb_rr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registers a one-hot grant for one of WIDTH requesters,
// holds it until a valid/ready handshake, then rotates priority past the winner.

module priority_finder #(
  parameter int WIDTH = 4,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IW-1:0]    index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

module rr_arbiter #(
  parameter int WIDTH = 4,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             out_ready,
  output logic [WIDTH-1:0] grant,
  output logic [IW-1:0]    grant_index,
  output logic             grant_valid,
  output logic [WIDTH-1:0] ack
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IW-1:0]    index_q, index_d;

  logic [IW-1:0]    ptr_after;
  logic [WIDTH-1:0] arb_v;
  logic [IW-1:0]    arb_p;
  logic [WIDTH-1:0] masked_v;
  logic             masked_found, raw_found;
  logic [IW-1:0]    masked_index, raw_index;
  logic [IW-1:0]    winner;

  // During a handshake the current winner is excluded and the search starts
  // just past it, so a new request can be granted in the same cycle.
  always_comb begin
    ptr_after = (index_q == IW'(WIDTH - 1)) ? '0 : index_q + IW'(1);
    if (state_q == GRANT) begin
      arb_v = req & ~grant_q;
      arb_p = ptr_after;
    end else begin
      arb_v = req;
      arb_p = ptr_q;
    end
    masked_v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      masked_v[i] = arb_v[i] && (i >= int'(arb_p));
    end
  end

  priority_finder #(.WIDTH(WIDTH)) u_masked_find (
    .vec   (masked_v),
    .found (masked_found),
    .index (masked_index)
  );

  priority_finder #(.WIDTH(WIDTH)) u_raw_find (
    .vec   (arb_v),
    .found (raw_found),
    .index (raw_index)
  );

  assign winner = masked_found ? masked_index : raw_index;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (raw_found) begin
          grant_d = WIDTH'(1) << winner;
          index_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (out_ready) begin
          ptr_d = ptr_after;
          if (raw_found) begin
            grant_d = WIDTH'(1) << winner;
            index_d = winner;
          end else begin
            grant_d = '0;
            index_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        index_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      index_q <= index_d;
    end
  end

  assign grant       = grant_q;
  assign grant_index = index_q;
  assign grant_valid = (state_q == GRANT);
  assign ack         = grant_q & {WIDTH{grant_valid & out_ready}};

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a rotating-search reference model predicts
// each cycle's outputs, and a negedge monitor compares them against the DUT.

module tb_rr_arbiter;

  localparam int W  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req;
  logic          out_ready;
  logic [W-1:0]  grant;
  logic [IW-1:0] grant_index;
  logic          grant_valid;
  logic [W-1:0]  ack;

  typedef struct {
    logic [W-1:0]  grant;
    logic [IW-1:0] index;
    logic          valid;
    logic [W-1:0]  ack;
  } exp_t;

  exp_t sb_q[$];
  int   check_count = 0;
  int   fail_count  = 0;

  // Reference model: "busy" plus winner index and rotating pointer.
  bit   m_busy;
  int   m_idx;
  int   m_ptr;

  rr_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid),
    .ack         (ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // First requester found when scanning upward from p, wrapping around.
  function automatic int arbRef(logic [W-1:0] v, int p);
    for (int k = 0; k < W; k++) begin
      int i;
      i = (p + k) % W;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    m_busy = 1'b0;
    m_idx  = 0;
    m_ptr  = 0;
  endfunction

  function automatic void modelStep(logic [W-1:0] r, logic rdy);
    logic [W-1:0] v;
    int w;
    if (!m_busy) begin
      w = arbRef(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_idx  = w;
      end
    end else if (rdy) begin
      m_ptr = (m_idx + 1) % W;
      v = r;
      v[m_idx] = 1'b0;
      w = arbRef(v, m_ptr);
      if (w >= 0) m_idx = w;
      else begin
        m_busy = 1'b0;
        m_idx  = 0;
      end
    end
  endfunction

  // Advance one edge, update the model with the inputs seen at that edge,
  // then drive the next inputs and queue what the DUT should show this cycle.
  task automatic applyStimulus(input logic [W-1:0] r, input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    modelStep(req, out_ready);
    req       = r;
    out_ready = rdy;
    e.valid = m_busy;
    e.grant = m_busy ? W'(1) << m_idx : '0;
    e.index = m_busy ? IW'(m_idx) : '0;
    e.ack   = (m_busy && rdy) ? e.grant : '0;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checkOutput("grant",       32'(grant),       32'(e.grant));
      checkOutput("grant_index", 32'(grant_index), 32'(e.index));
      checkOutput("grant_valid", 32'(grant_valid), 32'(e.valid));
      checkOutput("ack",         32'(ack),         32'(e.ack));
    end
  end

  initial begin
    rst = 1'b1;
    req = '1;
    out_ready = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_index", 32'(grant_index), 32'h0);
    checkOutput("reset_valid", 32'(grant_valid), 32'h0);
    checkOutput("reset_ack",   32'(ack), 32'h0);
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Release with all requesting, then fairness sweep with everyone re-raising.
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    // Single requester, then it drops after its ack.
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    // Backpressure with a mid-stall extra request, then release and wrap.
    for (int i = 0; i < 5; i++) applyStimulus(4'b1010, 1'b0);
    applyStimulus(4'b1011, 1'b0);
    applyStimulus(4'b1011, 1'b0);
    applyStimulus(4'b1011, 1'b1);
    applyStimulus(4'b1001, 1'b1);
    applyStimulus(4'b1001, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    // Lone requester held high: grants only every other cycle.
    for (int i = 0; i < 6; i++) applyStimulus(4'b1000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(W'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    // Reset mid-grant: outputs must clear before the next edge.
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("pre_reset_valid", 32'(grant_valid), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_grant", 32'(grant), 32'h0);
    checkOutput("midreset_valid", 32'(grant_valid), 32'h0);
    checkOutput("midreset_ack",   32'(ack), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    modelReset();
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0110, 1'b1);
    applyStimulus(4'b0010, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      fail_count++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
